// File: rtl/sim_oddr_tx.sv
// sim_oddr_tx: simulation-model DDR transmitter.
// Words arrive over a valid/ready handshake into a one-word holding register
// and are serialised MSB-first, two bits per clock: Q1 is the rising-half bit,
// Q2 the falling-half bit, and Q muxes them onto one DDR line using C.
// Optional feature macro: SIM_ODDR_TRAIN_EN (training pattern after reset).
module sim_oddr_tx #(
  parameter int   WIDTH        = 8,
  parameter logic IDLE_LEVEL   = 1'b0,
  parameter int   TRAIN_CYCLES = 16
) (
  input  logic             C,
  input  logic             R,
  input  logic             CE,
  input  logic             S,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic             Q1,
  output logic             Q2,
  output logic             Q,
  output logic             FRAME,
  output logic             TRAINING
);

  localparam int NPAIRS = WIDTH / 2;
  localparam int CNT_W  = $clog2(NPAIRS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NPAIRS);

  // An illegal configuration (odd or too-narrow word) never accepts data.
  localparam bit PARAMS_OK = (WIDTH >= 2) && ((WIDTH % 2) == 0) && (TRAIN_CYCLES >= 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_TRAIN = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_hold_data;
  logic             r_hold_valid;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_pair_cnt;
  logic             r_q1;
  logic             r_q2;
  logic             r_frame;

`ifdef SIM_ODDR_TRAIN_EN
  localparam int TRAIN_W = $clog2(TRAIN_CYCLES + 1) + 1;
  logic [TRAIN_W-1:0] r_train_cnt;
  logic               r_training;
`endif

  logic w_run;
  logic w_ready;
  logic w_xfer;
  logic w_word_done;
  logic w_load;

  // Set and clock-enable both freeze the datapath; only a running cycle advances.
  assign w_run       = CE & ~S;
  assign w_ready     = PARAMS_OK & ~r_hold_valid & (r_state != ST_TRAIN) & w_run & ~R;
  assign w_xfer      = DIN_VALID & w_ready;
  // Shifter has emitted the last pair of its word on the previous edge.
  assign w_word_done = (r_state == ST_SEND) && (r_pair_cnt == LAST_CNT);
  // Holding register moves into the shifter when the shifter is idle or finishing.
  assign w_load      = w_run & r_hold_valid & ((r_state == ST_IDLE) | w_word_done);

  // Holding register: capture on handshake, release when the shifter takes it.
  always_ff @(posedge C) begin
    if (R) begin
      r_hold_valid <= 1'b0;
    end else if (w_run) begin
      if (w_xfer) begin
        // A capture coinciding with a release leaves the new word held.
        r_hold_data  <= DIN;
        r_hold_valid <= 1'b1;
      end else if (w_load) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

  // Serialiser state machine with registered Q1/Q2/FRAME outputs.
  always_ff @(posedge C) begin
    if (R) begin
      r_q1       <= IDLE_LEVEL;
      r_q2       <= IDLE_LEVEL;
      r_frame    <= 1'b0;
      r_pair_cnt <= '0;
      r_shift    <= '0;
`ifdef SIM_ODDR_TRAIN_EN
      r_state     <= ST_TRAIN;
      r_train_cnt <= '0;
      r_training  <= 1'b0;
`else
      r_state    <= ST_IDLE;
`endif
    end else if (S) begin
      // Force the line high; position in the word (and training count) is kept.
      r_q1 <= 1'b1;
      r_q2 <= 1'b1;
    end else if (CE) begin
      if (w_load) begin
        // Pair 0 of the held word goes straight to the outputs; the rest
        // is left-aligned in the shifter for the following edges.
        r_q1       <= r_hold_data[WIDTH-1];
        r_q2       <= r_hold_data[WIDTH-2];
        r_shift    <= r_hold_data << 2;
        r_pair_cnt <= CNT_W'(1);
        r_frame    <= 1'b1;
        r_state    <= ST_SEND;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_q1    <= IDLE_LEVEL;
            r_q2    <= IDLE_LEVEL;
            r_frame <= 1'b0;
          end
          ST_SEND: begin
            if (w_word_done) begin
              // Nothing queued behind this word: drop back to idle level.
              r_q1       <= IDLE_LEVEL;
              r_q2       <= IDLE_LEVEL;
              r_frame    <= 1'b0;
              r_pair_cnt <= '0;
              r_state    <= ST_IDLE;
            end else begin
              r_q1       <= r_shift[WIDTH-1];
              r_q2       <= r_shift[WIDTH-2];
              r_shift    <= r_shift << 2;
              r_pair_cnt <= r_pair_cnt + 1'b1;
            end
          end
`ifdef SIM_ODDR_TRAIN_EN
          ST_TRAIN: begin
            if (r_train_cnt == TRAIN_W'(TRAIN_CYCLES)) begin
              r_q1       <= IDLE_LEVEL;
              r_q2       <= IDLE_LEVEL;
              r_training <= 1'b0;
              r_state    <= ST_IDLE;
            end else begin
              // Training pattern is a plain 1/0 toggle on the DDR line.
              r_q1        <= 1'b1;
              r_q2        <= 1'b0;
              r_training  <= 1'b1;
              r_train_cnt <= r_train_cnt + 1'b1;
            end
          end
`endif
          default: begin
            r_q1    <= IDLE_LEVEL;
            r_q2    <= IDLE_LEVEL;
            r_frame <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign DIN_READY = w_ready;
  assign Q1        = r_q1;
  assign Q2        = r_q2;
  assign FRAME     = r_frame;
  // DDR output: rising-half bit while the clock is high, falling-half while low.
  assign Q         = C ? r_q1 : r_q2;

`ifdef SIM_ODDR_TRAIN_EN
  assign TRAINING = r_training;
`else
  assign TRAINING = 1'b0;
`endif

endmodule

// File: tb/tb_sim_oddr_tx.sv
// Bench for sim_oddr_tx: table of per-cycle vectors for the 8-bit instance,
// a Q-line loopback of every byte value, and a short sequence on a 2-bit
// instance with a high idle level.
module tb_sim_oddr_tx;

  logic       C = 1'b0;
  logic       R = 1'b1;
  logic       CE = 1'b1;
  logic       S = 1'b0;
  logic [7:0] DIN = 8'h00;
  logic       DIN_VALID = 1'b0;
  logic       DIN_READY, Q1, Q2, Q, FRAME, TRAINING;

  logic [1:0] din2 = 2'b00;
  logic       valid2 = 1'b0;
  logic       ready2, q1_2, q2_2, q_2, frame2, training2;

  int checks = 0;
  int errors = 0;

  always #5 C = ~C;

  sim_oddr_tx #(.WIDTH(8), .IDLE_LEVEL(1'b0), .TRAIN_CYCLES(16)) u_dut (
    .C(C), .R(R), .CE(CE), .S(S), .DIN(DIN), .DIN_VALID(DIN_VALID),
    .DIN_READY(DIN_READY), .Q1(Q1), .Q2(Q2), .Q(Q), .FRAME(FRAME), .TRAINING(TRAINING)
  );

  sim_oddr_tx #(.WIDTH(2), .IDLE_LEVEL(1'b1), .TRAIN_CYCLES(16)) u_dut2 (
    .C(C), .R(R), .CE(CE), .S(S), .DIN(din2), .DIN_VALID(valid2),
    .DIN_READY(ready2), .Q1(q1_2), .Q2(q2_2), .Q(q_2), .FRAME(frame2), .TRAINING(training2)
  );

  typedef struct {
    logic       r;
    logic       ce;
    logic       s;
    logic       v;
    logic [7:0] din;
    logic       rdy;
    logic       q1;
    logic       q2;
    logic       fr;
  } vec_t;

  vec_t vecs[$];

  int         lb_words;
  int         lb_cyc;
  int         lb_np;
  int         fd_guard;
  logic [7:0] lb_acc;
  logic       lb_hi;
  logic       lb_lo;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Row: inputs for one cycle, DIN_READY expected in that cycle, and
  // Q1/Q2/FRAME expected after the following rising edge.
  task automatic add(input logic r, ce, s, v, input logic [7:0] d,
                     input logic rdy, q1, q2, fr);
    vec_t t;
    t.r = r; t.ce = ce; t.s = s; t.v = v; t.din = d;
    t.rdy = rdy; t.q1 = q1; t.q2 = q2; t.fr = fr;
    vecs.push_back(t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //  r  ce s  v  din    rdy q1 q2 fr
    // Reset, then single word A5 -> (1,0),(1,0),(0,1),(0,1)
    add(1, 1, 0, 0, 8'h00, 0,  0, 0, 0);
    add(0, 1, 0, 1, 8'hA5, 1,  0, 0, 0);
    add(0, 1, 0, 0, 8'h00, 0,  1, 0, 1);
    add(0, 1, 0, 0, 8'h00, 1,  1, 0, 1);
    add(0, 1, 0, 0, 8'h00, 1,  0, 1, 1);
    add(0, 1, 0, 0, 8'h00, 1,  0, 1, 1);
    add(0, 1, 0, 0, 8'h00, 1,  0, 0, 0);
    add(0, 1, 0, 0, 8'h00, 1,  0, 0, 0);
    // Back-to-back F0 then 0F with no gap in FRAME
    add(0, 1, 0, 1, 8'hF0, 1,  0, 0, 0);
    add(0, 1, 0, 1, 8'h0F, 0,  1, 1, 1);
    add(0, 1, 0, 1, 8'h0F, 1,  1, 1, 1);
    add(0, 1, 0, 1, 8'h0F, 0,  0, 0, 1);
    add(0, 1, 0, 1, 8'h0F, 0,  0, 0, 1);
    add(0, 1, 0, 0, 8'h0F, 0,  0, 0, 1);
    add(0, 1, 0, 0, 8'h00, 1,  0, 0, 1);
    add(0, 1, 0, 0, 8'h00, 1,  1, 1, 1);
    add(0, 1, 0, 0, 8'h00, 1,  1, 1, 1);
    add(0, 1, 0, 0, 8'h00, 1,  0, 0, 0);
    // C6 with CE low for 3 cycles after pair 1 (valid offered while CE low)
    add(0, 1, 0, 1, 8'hC6, 1,  0, 0, 0);
    add(0, 1, 0, 0, 8'h00, 0,  1, 1, 1);
    add(0, 1, 0, 0, 8'h00, 1,  0, 0, 1);
    add(0, 0, 0, 1, 8'hFF, 0,  0, 0, 1);
    add(0, 0, 0, 0, 8'h00, 0,  0, 0, 1);
    add(0, 0, 0, 0, 8'h00, 0,  0, 0, 1);
    add(0, 1, 0, 0, 8'h00, 1,  0, 1, 1);
    add(0, 1, 0, 0, 8'h00, 1,  1, 0, 1);
    add(0, 1, 0, 0, 8'h00, 1,  0, 0, 0);
    // 93 with S high for 2 cycles after pair 0
    add(0, 1, 0, 1, 8'h93, 1,  0, 0, 0);
    add(0, 1, 0, 0, 8'h00, 0,  1, 0, 1);
    add(0, 1, 1, 0, 8'h00, 0,  1, 1, 1);
    add(0, 1, 1, 1, 8'h00, 0,  1, 1, 1);
    add(0, 1, 0, 0, 8'h00, 1,  0, 1, 1);
    add(0, 1, 0, 0, 8'h00, 1,  0, 0, 1);
    add(0, 1, 0, 0, 8'h00, 1,  1, 1, 1);
    add(0, 1, 0, 0, 8'h00, 1,  0, 0, 0);
    // FF in flight with AA held, then reset: both discarded
    add(0, 1, 0, 1, 8'hFF, 1,  0, 0, 0);
    add(0, 1, 0, 1, 8'hAA, 0,  1, 1, 1);
    add(0, 1, 0, 1, 8'hAA, 1,  1, 1, 1);
    add(1, 1, 0, 0, 8'h00, 0,  0, 0, 0);
    add(0, 1, 0, 0, 8'h00, 1,  0, 0, 0);
    add(0, 1, 0, 0, 8'h00, 1,  0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge C);
      R = vecs[i].r; CE = vecs[i].ce; S = vecs[i].s;
      DIN_VALID = vecs[i].v; DIN = vecs[i].din;
      #1;
      chk1($sformatf("row%0d ready", i), DIN_READY, vecs[i].rdy);
      @(posedge C);
      #1;
      chk1($sformatf("row%0d q1", i), Q1, vecs[i].q1);
      chk1($sformatf("row%0d q2", i), Q2, vecs[i].q2);
      chk1($sformatf("row%0d frame", i), FRAME, vecs[i].fr);
      chk1($sformatf("row%0d q_line_high", i), Q, vecs[i].q1);
      chk1($sformatf("row%0d training", i), TRAINING, 1'b0);
    end

    // Loopback: rebuild every byte from the Q line (high half, then low half).
    @(negedge C);
    R = 1'b0; CE = 1'b1; S = 1'b0; DIN_VALID = 1'b0;
    lb_words = 0; lb_cyc = 0; lb_np = 0; lb_acc = 8'h00;
    fork
      begin
        for (int w = 0; w < 256; w++) begin
          @(negedge C);
          DIN_VALID = 1'b1;
          DIN = 8'(w);
          #1;
          fd_guard = 0;
          while (!DIN_READY && fd_guard < 20) begin
            @(negedge C);
            #1;
            fd_guard++;
          end
          if (!DIN_READY) begin
            chk1("loopback ready timeout", DIN_READY, 1'b1);
            break;
          end
          @(posedge C);
        end
        @(negedge C);
        DIN_VALID = 1'b0;
      end
      begin
        while (lb_words < 256 && lb_cyc < 3000) begin
          @(posedge C);
          #2;
          lb_cyc++;
          if (FRAME) begin
            lb_hi = Q;
            @(negedge C);
            #2;
            lb_lo = Q;
            lb_acc = {lb_acc[5:0], lb_hi, lb_lo};
            lb_np++;
            if (lb_np == 4) begin
              chk8($sformatf("loopback word%0d", lb_words), lb_acc, 8'(lb_words));
              lb_words++;
              lb_np = 0;
            end
          end
        end
      end
    join
    checks++;
    if (lb_words != 256) begin
      errors++;
      $display("FAIL loopback word count: got %0d expected 256", lb_words);
    end

    // WIDTH=2 instance, idle level high: one word is one pair.
    repeat (3) @(negedge C);
    #1;
    chk1("w2 idle q1", q1_2, 1'b1);
    chk1("w2 idle q2", q2_2, 1'b1);
    chk1("w2 idle frame", frame2, 1'b0);
    @(negedge C);
    valid2 = 1'b1; din2 = 2'b10;
    #1;
    chk1("w2 ready before", ready2, 1'b1);
    @(posedge C);
    #1;
    chk1("w2 capture q1", q1_2, 1'b1);
    chk1("w2 capture q2", q2_2, 1'b1);
    chk1("w2 capture frame", frame2, 1'b0);
    @(negedge C);
    valid2 = 1'b0;
    #1;
    chk1("w2 ready held", ready2, 1'b0);
    @(posedge C);
    #1;
    chk1("w2 pair0 q1", q1_2, 1'b1);
    chk1("w2 pair0 q2", q2_2, 1'b0);
    chk1("w2 pair0 frame", frame2, 1'b1);
    @(negedge C);
    #1;
    chk1("w2 ready after load", ready2, 1'b1);
    chk1("w2 q line low half", q_2, 1'b0);
    @(posedge C);
    #1;
    chk1("w2 back idle q1", q1_2, 1'b1);
    chk1("w2 back idle q2", q2_2, 1'b1);
    chk1("w2 back idle frame", frame2, 1'b0);
    chk1("w2 training", training2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
